// File: rtl/servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_bank
// Purpose  : N-channel servo PWM bank fed by one ADC sample port; samples are
//            scaled by a shift-add multiplier and widths slew once per frame.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_bank #(
    parameter int N_CH       = 5,
    parameter int ADC_W      = 8,
    parameter int PERIOD_CYC = 1000000,
    parameter int MIN_CYC    = 50000,
    parameter int MAX_CYC    = 100000,
    parameter int STEP_CYC   = 0,
    localparam int c_cw      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [c_cw-1:0]  sample_ch,
    input  logic [ADC_W-1:0] sample_data,
    output logic [N_CH-1:0]  pwm_out,
    output logic             frame_start,
    output logic             ch_err
);

    localparam int c_pw   = $clog2(PERIOD_CYC);
    localparam int c_span = MAX_CYC - MIN_CYC;
    localparam int c_sw   = $clog2(c_span + 1);
    localparam int c_prw  = ADC_W + c_sw;
    localparam int c_mw   = (ADC_W > 1) ? $clog2(ADC_W) : 1;

    localparam logic [c_pw-1:0]  c_center   = c_pw'((MIN_CYC + MAX_CYC) / 2);
    localparam logic [c_pw-1:0]  c_min      = c_pw'(MIN_CYC);
    localparam logic [c_pw-1:0]  c_step     = c_pw'(STEP_CYC);
    localparam logic [c_pw-1:0]  c_last     = c_pw'(PERIOD_CYC - 1);
    localparam logic [c_prw-1:0] c_span_p   = c_prw'(c_span);
    localparam logic [c_mw-1:0]  c_mul_last = c_mw'(ADC_W - 1);
    localparam logic [c_cw:0]    c_n_ch     = (c_cw + 1)'(N_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_pw-1:0]   r_cnt;
    logic              r_frame_start;
    logic              r_ch_err;
    logic [c_cw-1:0]   r_ch;
    logic [ADC_W-1:0]  r_mcand;
    logic [c_prw-1:0]  r_prod;
    logic [c_mw-1:0]   r_mcnt;
    logic [N_CH-1:0]   r_pwm;
    logic [N_CH-1:0]   w_pwm_nxt;
    logic              w_wrap;
    logic              w_write;
    logic              w_ch_bad;
    logic [c_pw-1:0]   w_new_target;

    assign w_wrap       = (r_cnt == c_last);
    assign w_write      = (r_state == ST_WRITE);
    assign w_ch_bad     = ({1'b0, r_ch} >= c_n_ch);
    assign w_new_target = c_min + c_pw'(r_prod[c_prw-1:ADC_W]);

    assign sample_ready = (r_state == ST_IDLE);
    assign frame_start  = r_frame_start;
    assign ch_err       = r_ch_err;
    assign pwm_out      = r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_wrap ? '0 : r_cnt + 1'b1;
            r_frame_start <= w_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (sample_valid) w_state_nxt = ST_MUL;
            ST_MUL:   if (r_mcnt == c_mul_last) w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // MSB-first shift-add: one multiplicand bit per MUL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch     <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mcnt   <= '0;
            r_ch_err <= 1'b0;
        end else begin
            r_ch_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        r_ch    <= sample_ch;
                        r_mcand <= sample_data;
                        r_prod  <= '0;
                        r_mcnt  <= '0;
                    end
                end
                ST_MUL: begin
                    r_prod  <= (r_prod << 1) + (r_mcand[ADC_W-1] ? c_span_p : '0);
                    r_mcand <= r_mcand << 1;
                    r_mcnt  <= r_mcnt + 1'b1;
                end
                ST_WRITE: r_ch_err <= w_ch_bad;
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [c_pw-1:0] r_target;
        logic [c_pw-1:0] r_width;
        logic [c_pw-1:0] w_width_nxt;

        always_comb begin
            w_width_nxt = r_target;
            if (STEP_CYC != 0) begin
                if ((r_target > r_width) && ((r_target - r_width) > c_step)) begin
                    w_width_nxt = r_width + c_step;
                end else if ((r_width > r_target) && ((r_width - r_target) > c_step)) begin
                    w_width_nxt = r_width - c_step;
                end
            end
        end

        // Width only moves on the wrap edge, so a pulse is never cut mid-frame.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_target <= c_center;
                r_width  <= c_center;
            end else begin
                if (w_write && !w_ch_bad && (r_ch == c_cw'(gi))) begin
                    r_target <= w_new_target;
                end
                if (w_wrap) begin
                    r_width <= w_width_nxt;
                end
            end
        end

        assign w_pwm_nxt[gi] = enable && (r_cnt < r_width);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end

endmodule
`default_nettype wire
